cond_branch_eval: RTL and testbench

COND_BRANCH_EVAL -- requirements
Module: cond_branch_eval

---
 rtl/cond_branch_eval.sv | 144 ++++++++++++++
 tb/tb_cond_branch_eval.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_branch_eval.sv
// Branch condition evaluator: captures ALU status flags and evaluates a 4-bit
// condition code behind a four-phase request/acknowledge handshake.
module cond_branch_eval #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       zin,
    input  logic       vin,
    input  logic       sin,
    input  logic       cin,
    input  logic       flag_ld,
    input  logic       flag_pend,
    input  logic       br_req,
    input  logic [3:0] br_cond,
    output logic       br_ack,
    output logic       br_taken,
    output logic       br_err,
    output logic       busy,
    output logic       zout,
    output logic       vout,
    output logic       sout,
    output logic       cout
);

    typedef enum logic [1:0] {IDLE, WAIT_FLAGS, EVAL, DONE} state_e;

    typedef struct packed {
        logic z;
        logic v;
        logic s;
        logic c;
    } flags_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    flags_t     flags_q, flags_d;
    logic [3:0] cond_q,  cond_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       taken_q, taken_d;
    logic       err_q,   err_d;
    logic       ack_q,   ack_d;

    function automatic logic cond_true(input logic [3:0] code, input flags_t f);
        logic t;
        case (code)
            4'h0:    t = 1'b1;
            4'h1:    t = 1'b0;
            4'h2:    t = f.z;
            4'h3:    t = !f.z;
            4'h4:    t = f.c;
            4'h5:    t = !f.c;
            4'h6:    t = f.s;
            4'h7:    t = !f.s;
            4'h8:    t = f.v;
            4'h9:    t = !f.v;
            4'hA:    t = (f.s == f.v);
            4'hB:    t = (f.s != f.v);
            4'hC:    t = !f.z && (f.s == f.v);
            4'hD:    t = f.z || (f.s != f.v);
            4'hE:    t = f.c && !f.z;
            default: t = !f.c || f.z;
        endcase
        return t;
    endfunction

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cond_d  = cond_q;
        cnt_d   = cnt_q;
        taken_d = taken_q;
        err_d   = err_q;
        ack_d   = 1'b0;
        flags_d = flag_ld ? flags_t'({zin, vin, sin, cin}) : flags_q;

        case (state_q)
            IDLE: begin
                if (br_req) begin
                    cond_d  = br_cond;
                    cnt_d   = 8'd0;
                    state_d = (flag_pend || flag_ld) ? WAIT_FLAGS : EVAL;
                end
            end
            WAIT_FLAGS: begin
                cnt_d = cnt_q + 8'd1;
                // A clean flag capture takes priority over an expiring timeout.
                if (flag_ld && !flag_pend) begin
                    state_d = EVAL;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    state_d = DONE;
                    taken_d = 1'b0;
                    err_d   = 1'b1;
                end
            end
            EVAL: begin
                taken_d = cond_true(cond_q, flags_q);
                err_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                // Ack is shown for at least one cycle, even if the request dropped early.
                if (ack_q && !br_req) begin
                    state_d = IDLE;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            flags_q <= '0;
            cond_q  <= '0;
            cnt_q   <= '0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cond_q  <= cond_d;
            cnt_q   <= cnt_d;
            taken_q <= taken_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
        end
    end

    assign br_ack   = ack_q;
    assign br_taken = ack_q & taken_q;
    assign br_err   = ack_q & err_q;
    assign busy     = (state_q != IDLE);
    assign zout     = flags_q.z;
    assign vout     = flags_q.v;
    assign sout     = flags_q.s;
    assign cout     = flags_q.c;

endmodule

// File: tb/tb_cond_branch_eval.sv
// Directed self-checking bench for cond_branch_eval, built with TIMEOUT=4.
module tb_cond_branch_eval;

    logic       clk = 1'b0;
    logic       reset;
    logic       zin, vin, sin, cin;
    logic       flag_ld, flag_pend;
    logic       br_req;
    logic [3:0] br_cond;
    logic       br_ack, br_taken, br_err, busy;
    logic       zout, vout, sout, cout;

    int errors = 0;
    int checks = 0;

    cond_branch_eval #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .zin(zin), .vin(vin), .sin(sin), .cin(cin),
        .flag_ld(flag_ld), .flag_pend(flag_pend),
        .br_req(br_req), .br_cond(br_cond),
        .br_ack(br_ack), .br_taken(br_taken), .br_err(br_err), .busy(busy),
        .zout(zout), .vout(vout), .sout(sout), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: even codes are base conditions, odd codes their negation.
    function automatic logic ref_taken(input logic [3:0] code, input logic [3:0] f);
        logic z, v, s, c, base;
        {z, v, s, c} = f;
        case (code[3:1])
            3'd0: base = 1'b1;
            3'd1: base = z;
            3'd2: base = c;
            3'd3: base = s;
            3'd4: base = v;
            3'd5: base = ~(s ^ v);
            3'd6: base = ~z & ~(s ^ v);
            default: base = c & ~z;
        endcase
        return base ^ code[0];
    endfunction

    task automatic load_flags(input logic [3:0] f);
        {zin, vin, sin, cin} = f;
        flag_ld = 1'b1;
        tick();
        flag_ld = 1'b0;
    endtask

    // No-hazard branch: ack expected after the second edge following acceptance.
    task automatic do_branch(input string tag, input logic [3:0] code, input logic exp_taken);
        br_cond = code;
        br_req  = 1'b1;
        tick();
        br_cond = ~code;
        check({tag, " busy"}, busy, 1);
        check({tag, " ack_n1"}, br_ack, 0);
        tick();
        check({tag, " ack_n2_early"}, br_ack, 0);
        tick();
        check({tag, " ack"}, br_ack, 1);
        check({tag, " taken"}, br_taken, exp_taken);
        check({tag, " err"}, br_err, 0);
        br_req = 1'b0;
        tick();
        check({tag, " ack_drop"}, br_ack, 0);
        check({tag, " taken_gated"}, br_taken, 0);
        check({tag, " idle"}, busy, 0);
    endtask

    initial begin
        reset = 1'b0;
        {zin, vin, sin, cin} = 4'b0;
        flag_ld = 1'b0; flag_pend = 1'b0;
        br_req = 1'b0; br_cond = 4'h0;
        #2;
        check("rst ack", br_ack, 0);
        check("rst busy", busy, 0);
        check("rst taken", br_taken, 0);
        check("rst err", br_err, 0);
        check("rst flags", {zout, vout, sout, cout}, 4'b0000);
        #1 reset = 1'b1;

        // Z=1, cond=2
        load_flags(4'b1000);
        check("flag load", {zout, vout, sout, cout}, 4'b1000);
        br_cond = 4'h2; br_req = 1'b1;
        tick();
        tick();
        tick();
        check("z ack", br_ack, 1);
        check("z taken", br_taken, 1);
        check("z err", br_err, 0);
        // Flag reload while acking must not disturb the result.
        load_flags(4'b0000);
        check("done hold ack", br_ack, 1);
        check("done hold taken", br_taken, 1);
        br_req = 1'b0;
        tick();
        check("z ack drop", br_ack, 0);

        // S=1, V=0
        load_flags(4'b0010);
        do_branch("cond A", 4'hA, 1'b0);
        do_branch("cond B", 4'hB, 1'b1);
        do_branch("cond D", 4'hD, 1'b1);

        // Flags pending: new C delivered three cycles after acceptance.
        load_flags(4'b0000);
        flag_pend = 1'b1; br_cond = 4'h4; br_req = 1'b1;
        tick();
        check("pend busy", busy, 1);
        tick();
        tick();
        check("pend wait ack", br_ack, 0);
        cin = 1'b1; flag_ld = 1'b1; flag_pend = 1'b0;
        tick();
        flag_ld = 1'b0;
        check("pend c loaded", cout, 1);
        tick();
        check("pend ack early", br_ack, 0);
        tick();
        check("pend ack", br_ack, 1);
        check("pend taken", br_taken, 1);
        check("pend err", br_err, 0);
        br_req = 1'b0;
        tick();
        check("pend ack drop", br_ack, 0);

        // Timeout after four WAIT_FLAGS cycles.
        flag_pend = 1'b1; br_cond = 4'h0; br_req = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        check("to before", br_ack, 0);
        tick();
        check("to done no ack yet", br_ack, 0);
        check("to busy", busy, 1);
        tick();
        check("to ack", br_ack, 1);
        check("to err", br_err, 1);
        check("to taken", br_taken, 0);
        tick();
        tick();
        check("to ack hold", br_ack, 1);
        check("to err hold", br_err, 1);
        br_req = 1'b0;
        tick();
        check("to ack drop", br_ack, 0);
        check("to err gated", br_err, 0);
        flag_pend = 1'b0;

        // Request withdrawn early: completion still runs and is acknowledged.
        load_flags(4'b1000);
        br_cond = 4'h3; br_req = 1'b1;
        tick();
        br_req = 1'b0;
        tick();
        tick();
        check("early drop ack", br_ack, 1);
        check("early drop taken", br_taken, 0);
        tick();
        check("early drop exit", br_ack, 0);
        check("early drop idle", busy, 0);

        // Asynchronous reset during WAIT_FLAGS, then re-accept of a held request.
        load_flags(4'b1111);
        flag_pend = 1'b1; br_cond = 4'h0; br_req = 1'b1;
        tick();
        tick();
        check("pre-rst busy", busy, 1);
        reset = 1'b0;
        #2;
        check("async rst busy", busy, 0);
        check("async rst ack", br_ack, 0);
        check("async rst flags", {zout, vout, sout, cout}, 4'b0000);
        flag_pend = 1'b0;
        #1 reset = 1'b1;
        tick();
        check("re-accept busy", busy, 1);
        tick();
        tick();
        check("re-accept ack", br_ack, 1);
        check("re-accept taken", br_taken, 1);
        br_req = 1'b0;
        tick();

        // Full sweep of codes against flag combinations.
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                do_branch($sformatf("sweep c=%0h f=%0h", c, f), 4'(c), ref_taken(4'(c), 4'(f)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
